// File: rtl/dmem_slot_arbiter_pkg.sv
// Shared pipeline definitions: data-memory arbiter states,
// exception vector and cause codes for the Cause register.
package pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT0 = 2'd1,
        WAIT1 = 2'd2,
        ERR   = 2'd3
    } arb_state_t;

    localparam logic [31:0] EXC_VECTOR         = 32'd60;
    localparam logic [4:0]  CAUSE_MISALIGN     = 5'd4;
    localparam logic [4:0]  CAUSE_DMEM_TIMEOUT = 5'd5;

    function automatic logic misaligned(input logic [1:0] lo);
        return lo != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_slot_arbiter_if.sv
// Single-port data memory bus with a ready handshake.
interface dmem_slot_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ready
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ready
    );
endinterface

// File: rtl/dmem_slot_arbiter_wait_timer.sv
// Counts consecutive unanswered memory cycles; expired flags
// the last permitted wait cycle of an access.
module dmem_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign expired = en && (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/dmem_slot_arbiter.sv
// Serves the two VLIW slots' loads/stores on the single-port
// data memory in program order, stalling until the bundle is done.
module dmem_slot_arbiter
    import pipeline_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              s0_req,
    input  logic              s0_we,
    input  logic [ADDR_W-1:0] s0_addr,
    input  logic [DATA_W-1:0] s0_wdata,
    input  logic              s1_req,
    input  logic              s1_we,
    input  logic [ADDR_W-1:0] s1_addr,
    input  logic [DATA_W-1:0] s1_wdata,
    output logic [DATA_W-1:0] s0_rdata,
    output logic [DATA_W-1:0] s1_rdata,
    output logic              s0_done,
    output logic              s1_done,
    output logic              stall,
    output logic              bus_err,
    output logic              err_slot,
    dmem_slot_arbiter_if.master mem
);
    arb_state_t        state, state_nx;
    logic              sel0, sel1, act, mis, go, hit;
    logic              wait_en, wait_clr, tmo;
    logic [DATA_W-1:0] r0, r1;

    always_comb begin
        sel0 = 1'b0;
        sel1 = 1'b0;
        case (state)
            IDLE: begin
                sel0 = s0_req;
                sel1 = !s0_req && s1_req;
            end
            WAIT0:   sel0 = 1'b1;
            WAIT1:   sel1 = 1'b1;
            default: ;
        endcase
    end

    assign act = reset && (sel0 || sel1);
    assign mis = act && (sel0 ? misaligned(s0_addr[1:0])
                              : misaligned(s1_addr[1:0]));
    assign go  = act && !mis && !flush;
    assign hit = go && mem.ready;

    assign mem.req   = go;
    assign mem.we    = sel0 ? s0_we    : s1_we;
    assign mem.addr  = sel0 ? s0_addr  : s1_addr;
    assign mem.wdata = sel0 ? s0_wdata : s1_wdata;

    assign s0_done  = hit && sel0;
    assign s1_done  = hit && sel1;
    assign s0_rdata = s0_done ? mem.rdata : r0;
    assign s1_rdata = s1_done ? mem.rdata : r1;

    // The pipeline advances in the cycle the last needed access completes
    assign stall   = act && !flush && !(s0_done && !s1_req) && !s1_done;
    assign bus_err = reset && (state == ERR);

    assign wait_en  = go && !mem.ready;
    assign wait_clr = !wait_en;

    dmem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (wait_clr),
        .en      (wait_en),
        .expired (tmo)
    );

    always_comb begin
        state_nx = state;
        if (flush || state == ERR)
            state_nx = IDLE;
        else if (mis)
            state_nx = ERR;
        else if (hit)
            state_nx = (s0_done && s1_req) ? WAIT1 : IDLE;
        else if (tmo)
            state_nx = ERR;
        else if (go)
            state_nx = sel0 ? WAIT0 : WAIT1;
        else
            state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            r0       <= '0;
            r1       <= '0;
            err_slot <= 1'b0;
        end else begin
            state <= state_nx;
            if (s0_done)
                r0 <= mem.rdata;
            if (s1_done)
                r1 <= mem.rdata;
            if (!flush && state != ERR && (mis || tmo))
                err_slot <= sel1;
        end
    end
endmodule

// File: tb/tb_dmem_slot_arbiter.sv
// Self-checking bench: vector table, directed corner sequences and
// randomized bundles against a transaction-level memory model.
module tb_dmem_slot_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        s0_req = 1'b0, s0_we = 1'b0;
    logic        s1_req = 1'b0, s1_we = 1'b0;
    logic [31:0] s0_addr = '0, s1_addr = '0;
    logic [31:0] s0_wdata = '0, s1_wdata = '0;
    logic [31:0] s0_rdata, s1_rdata;
    logic        s0_done, s1_done, stall, bus_err, err_slot;
    int          pass_n = 0;
    int          total_n = 0;

    dmem_slot_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mif ();

    dmem_slot_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .s0_req   (s0_req),
        .s0_we    (s0_we),
        .s0_addr  (s0_addr),
        .s0_wdata (s0_wdata),
        .s1_req   (s1_req),
        .s1_we    (s1_we),
        .s1_addr  (s1_addr),
        .s1_wdata (s1_wdata),
        .s0_rdata (s0_rdata),
        .s1_rdata (s1_rdata),
        .s0_done  (s0_done),
        .s1_done  (s1_done),
        .stall    (stall),
        .bus_err  (bus_err),
        .err_slot (err_slot),
        .mem      (mif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r0;
        logic [31:0] a0;
        logic        w0;
        logic        r1;
        logic [31:0] a1;
        logic        rdy;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_we;
        logic        e_stall;
        logic        e_d0;
        logic        e_d1;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total_n++;
        if (act === exp)
            pass_n++;
        else
            $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc, nreq, k, wt, nerr, exp_cyc;
        int          lat[2];
        int          exp_slot[$];
        logic [31:0] got[2];
        logic        seen_err, fin;

        mif.ready = 1'b0;
        mif.rdata = '0;

        // Reset state, with a request already presented
        s0_req = 1'b1; s0_addr = 32'h10; mif.ready = 1'b1;
        mif.rdata = 32'h99;
        #4;
        chk("rst mem_req", mif.req, 0);
        chk("rst stall", stall, 0);
        chk("rst s0_done", s0_done, 0);
        chk("rst bus_err", bus_err, 0);
        chk("rst err_slot", err_slot, 0);
        chk("rst s0_rdata", s0_rdata, 0);
        s0_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        vt[0] = '{0, 32'h0,  0, 0, 32'h0,  1, 32'h0,        0, 32'h0,  0, 0, 0, 0};
        vt[1] = '{1, 32'h10, 0, 0, 32'h0,  1, 32'hDEADBEEF, 1, 32'h10, 0, 0, 1, 0};
        vt[2] = '{1, 32'h20, 1, 1, 32'h24, 1, 32'h5,        1, 32'h20, 1, 1, 1, 0};
        vt[3] = '{1, 32'h30, 0, 0, 32'h0,  0, 32'h0,        1, 32'h30, 0, 1, 0, 0};
        vt[4] = '{0, 32'h0,  0, 1, 32'h44, 1, 32'h1234,     1, 32'h44, 0, 0, 0, 1};
        vt[5] = '{0, 32'h0,  0, 1, 32'h22, 1, 32'h0,        0, 32'h0,  0, 1, 0, 0};
        vt[6] = '{1, 32'h13, 0, 1, 32'h40, 1, 32'h0,        0, 32'h0,  0, 1, 0, 0};
        vt[7] = '{1, 32'h50, 0, 1, 32'h51, 1, 32'h77,       1, 32'h50, 0, 1, 1, 0};

        for (int i = 0; i < 8; i++) begin
            s0_req = vt[i].r0; s0_addr = vt[i].a0; s0_we = vt[i].w0;
            s1_req = vt[i].r1; s1_addr = vt[i].a1; s1_we = 1'b0;
            mif.ready = vt[i].rdy; mif.rdata = vt[i].rd;
            #4;
            chk($sformatf("v%0d mem_req", i), mif.req, vt[i].e_req);
            if (vt[i].e_req) begin
                chk($sformatf("v%0d addr", i), mif.addr, vt[i].e_addr);
                chk($sformatf("v%0d we", i), mif.we, vt[i].e_we);
            end
            chk($sformatf("v%0d stall", i), stall, vt[i].e_stall);
            chk($sformatf("v%0d s0_done", i), s0_done, vt[i].e_d0);
            chk($sformatf("v%0d s1_done", i), s1_done, vt[i].e_d1);
            if (vt[i].e_d0)
                chk($sformatf("v%0d s0_rdata", i), s0_rdata, vt[i].rd);
            if (vt[i].e_d1)
                chk($sformatf("v%0d s1_rdata", i), s1_rdata, vt[i].rd);
            flush = 1'b1;
            tick();
            flush = 1'b0;
        end
        s0_req = 1'b0; s1_req = 1'b0;
        tick();

        // Dual access, zero-wait memory
        s0_req = 1'b1; s0_we = 1'b1; s0_addr = 32'h20;
        s0_wdata = 32'hCAFE0001;
        s1_req = 1'b1; s1_we = 1'b0; s1_addr = 32'h24;
        mif.ready = 1'b1; mif.rdata = 32'h11112222;
        #4;
        chk("dual c1 addr", mif.addr, 32'h20);
        chk("dual c1 we", mif.we, 1);
        chk("dual c1 wdata", mif.wdata, 32'hCAFE0001);
        chk("dual c1 stall", stall, 1);
        tick();
        mif.rdata = 32'h33334444;
        #4;
        chk("dual c2 addr", mif.addr, 32'h24);
        chk("dual c2 we", mif.we, 0);
        chk("dual c2 stall", stall, 0);
        chk("dual c2 s1_done", s1_done, 1);
        chk("dual c2 s1_rdata", s1_rdata, 32'h33334444);
        tick();
        s0_req = 1'b0; s1_req = 1'b0; s0_we = 1'b0;

        // Load with three wait cycles
        s0_req = 1'b1; s0_addr = 32'h30; mif.ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #4;
            chk($sformatf("lat3 stall c%0d", c), stall, 1);
            chk($sformatf("lat3 done c%0d", c), s0_done, 0);
            tick();
        end
        mif.ready = 1'b1; mif.rdata = 32'hA5A5A5A5;
        #4;
        chk("lat3 ready stall", stall, 0);
        chk("lat3 ready done", s0_done, 1);
        chk("lat3 ready rdata", s0_rdata, 32'hA5A5A5A5);
        tick();
        s0_req = 1'b0; mif.rdata = 32'h0;
        #4;
        chk("lat3 held rdata", s0_rdata, 32'hA5A5A5A5);
        tick();

        // Misaligned slot 1 load
        s1_req = 1'b1; s1_addr = 32'h22; mif.ready = 1'b1;
        #4;
        chk("mis mem_req", mif.req, 0);
        chk("mis bus_err early", bus_err, 0);
        tick();
        #4;
        chk("mis bus_err", bus_err, 1);
        chk("mis err_slot", err_slot, 1);
        chk("mis err stall", stall, 0);
        chk("mis err mem_req", mif.req, 0);
        tick();
        s1_req = 1'b0;
        #4;
        chk("mis bus_err pulse", bus_err, 0);
        chk("mis err_slot held", err_slot, 1);
        tick();

        // Timeout on a slot 0 load
        s0_req = 1'b1; s0_addr = 32'h60; mif.ready = 1'b0;
        cyc = 0; nreq = 0;
        while (cyc < 40) begin
            #4;
            if (bus_err)
                break;
            if (mif.req)
                nreq++;
            cyc++;
            tick();
        end
        chk("tmo cycles", cyc, 16);
        chk("tmo req cycles", nreq, 16);
        chk("tmo bus_err", bus_err, 1);
        chk("tmo err_slot", err_slot, 0);
        tick();
        s0_req = 1'b0; s1_req = 1'b1; s1_addr = 32'h70;
        mif.ready = 1'b1;
        #4;
        chk("tmo idle addr", mif.addr, 32'h70);
        chk("tmo idle s1_done", s1_done, 1);
        tick();
        s1_req = 1'b0;

        // Flush in WAIT1 together with mem_ready
        s0_req = 1'b1; s0_addr = 32'h80;
        s1_req = 1'b1; s1_addr = 32'h84; mif.ready = 1'b1;
        #4;
        tick();
        flush = 1'b1;
        #4;
        chk("flush s1_done", s1_done, 0);
        chk("flush stall", stall, 0);
        chk("flush mem_req", mif.req, 0);
        tick();
        flush = 1'b0; s1_req = 1'b0; s0_addr = 32'h90;
        mif.rdata = 32'h5A5A0000;
        #4;
        chk("flush idle addr", mif.addr, 32'h90);
        chk("flush idle s0_done", s0_done, 1);
        tick();
        s0_req = 1'b0;

        // Asynchronous reset while waiting in WAIT0
        s0_req = 1'b1; s0_addr = 32'hA0; mif.ready = 1'b0;
        #4;
        tick();
        #1;
        reset = 1'b0;
        #1;
        chk("areset mem_req", mif.req, 0);
        chk("areset stall", stall, 0);
        chk("areset s0_rdata", s0_rdata, 0);
        s0_req = 1'b0;
        tick();
        #2;
        reset = 1'b1;
        tick();

        // Randomized bundles against the transaction model
        for (int b = 0; b < 60; b++) begin
            s0_req = 1'($urandom_range(0, 1));
            s1_req = 1'($urandom_range(0, 1));
            s0_we = 1'($urandom_range(0, 1));
            s1_we = 1'($urandom_range(0, 1));
            s0_addr = $urandom & 32'hFFFF_FFFC;
            s1_addr = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0)
                s0_addr = s0_addr | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0)
                s1_addr = s1_addr | 32'($urandom_range(1, 3));
            s0_wdata = $urandom; s1_wdata = $urandom;
            lat[0] = $urandom_range(0, 4);
            lat[1] = $urandom_range(0, 4);

            exp_slot.delete();
            nerr = -1;
            if (s0_req) begin
                if (s0_addr[1:0] != 2'b00) nerr = 0;
                else exp_slot.push_back(0);
            end
            if (s1_req && nerr < 0) begin
                if (s1_addr[1:0] != 2'b00) nerr = 1;
                else exp_slot.push_back(1);
            end
            exp_cyc = (nerr >= 0) ? 2 : 0;
            foreach (exp_slot[j]) exp_cyc += lat[exp_slot[j]] + 1;
            if (exp_cyc == 0) exp_cyc = 1;

            cyc = 0; k = 0; wt = 0; seen_err = 1'b0;
            got[0] = '0; got[1] = '0;
            while (cyc < 40) begin
                #1;
                mif.ready = mif.req && k < exp_slot.size()
                            && wt >= lat[exp_slot[k]];
                mif.rdata = $urandom;
                #3;
                if (mif.req && k >= exp_slot.size()) begin
                    chk($sformatf("b%0d unexpected req", b), mif.req, 0);
                end else if (mif.req && mif.ready) begin
                    chk($sformatf("b%0d addr", b), mif.addr,
                        exp_slot[k] == 1 ? s1_addr : s0_addr);
                    chk($sformatf("b%0d we", b), mif.we,
                        exp_slot[k] == 1 ? s1_we : s0_we);
                    if (mif.we)
                        chk($sformatf("b%0d wdata", b), mif.wdata,
                            exp_slot[k] == 1 ? s1_wdata : s0_wdata);
                    chk($sformatf("b%0d s0_done", b), s0_done,
                        32'(exp_slot[k] == 0));
                    chk($sformatf("b%0d s1_done", b), s1_done,
                        32'(exp_slot[k] == 1));
                    got[exp_slot[k]] = mif.rdata;
                    k++;
                    wt = 0;
                end else if (mif.req) begin
                    wt++;
                end
                if (bus_err) begin
                    seen_err = 1'b1;
                    chk($sformatf("b%0d err_slot", b), err_slot,
                        32'(nerr == 1));
                end
                cyc++;
                fin = !stall;
                if (fin && nerr < 0) begin
                    if (s0_req && !s0_we)
                        chk($sformatf("b%0d s0_rdata", b), s0_rdata, got[0]);
                    if (s1_req && !s1_we)
                        chk($sformatf("b%0d s1_rdata", b), s1_rdata, got[1]);
                end
                tick();
                if (fin)
                    break;
            end
            chk($sformatf("b%0d cycles", b), cyc, exp_cyc);
            chk($sformatf("b%0d accesses", b), k, exp_slot.size());
            chk($sformatf("b%0d bus_err", b), seen_err, 32'(nerr >= 0));
        end

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule

// File: doc/dmem_slot_arbiter.md
# dmem_slot_arbiter

Sequences the two issue slots of the VLIW bundle onto the single-port data memory in the MEM stage. Slot 0 (32-bit instruction) and slot 1 (compressed instruction) may both issue a load/store in the same bundle; the arbiter serves them in program order (slot 0 first), tolerates a variable-latency memory via a ready handshake, and stalls the front of the pipeline until the bundle's memory work is complete. It also flags misaligned or timed-out accesses as bus errors for the exception logic (vector 60).

## Interface
- ADDR_W, 32, data memory byte address width
- DATA_W, 32, data word width
- TIMEOUT, 16, max cycles an access may wait for mem_ready before bus error (>=2)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; reset=0 clears all state immediately
- flush  in  1  pipeline flush; abandons the current bundle
- s0_req, s1_req  in  1  slot issues a memory access (EX/MEM register, held stable while stall=1)
- s0_we, s1_we  in  1  1 = store, 0 = load
- s0_addr, s1_addr  in  ADDR_W  byte address
- s0_wdata, s1_wdata  in  DATA_W  store data
- s0_rdata, s1_rdata  out  DATA_W  load data for MEM/WB capture
- s0_done, s1_done  out  1  one-cycle pulse: slot's access accepted by memory
- mem_req  out  1  memory access valid
- mem_we  out  1  store enable, valid with mem_req
- mem_addr  out  ADDR_W  address to memory
- mem_wdata  out  DATA_W  store data to memory
- mem_rdata  in  DATA_W  load data, valid when mem_ready=1
- mem_ready  in  1  memory completes the current access this cycle
- stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- bus_err  out  1  one-cycle error pulse to exception logic
- err_slot  out  1  slot that caused the last bus_err (registered, held)

## Operation
- States: IDLE, WAIT0, WAIT1, ERR.
- Memory mux: drives slot 0 in IDLE when s0_req=1 and in WAIT0. Drives slot 1 in IDLE when only s1_req=1 and in WAIT1. Otherwise mem_req=0.
- IDLE, s0_req:
  - mem_ready=1 → latch rdata, s0_done. Go to WAIT1 if s1_req, else stay in IDLE.
  - No ready → WAIT0.
- IDLE, only s1_req: ready → s1_done, stay in IDLE; no ready → WAIT1.
- WAIT0: on ready → s0_done, then WAIT1 if s1_req else IDLE.
- WAIT1: on ready → s1_done, then IDLE.
- stall: combinational.
  - 1 whenever a requested access of the current bundle is still outstanding.
  - 0 in the cycle the last needed access sees mem_ready, so the pipeline advances that edge.
  - Zero-wait single access: no stall.
  - Zero-wait dual access: exactly one stall cycle.
- Read data:
  - sN_rdata = mem_rdata when slot N is being served and mem_ready=1.
  - Otherwise sN_rdata is the registered copy latched at that slot's completion. This holds slot 0 data until the bundle retires.
- Misaligned access: addr[1:0]!=0 is never sent to memory (mem_req=0). The arbiter goes to ERR with err_slot=that slot. Slot 0 is checked before slot 1; slot 1 is not checked until slot 0 is done.
- Timeout: wait_cnt counts consecutive cycles with mem_req=1 and mem_ready=0, and clears on ready or on a state change. When wait_cnt reaches TIMEOUT-1 without ready, next state is ERR.
- ERR (one cycle):
  - bus_err=1, mem_req=0, stall=0, no done pulses.
  - Next state IDLE; requests are ignored in ERR.
- flush=1 (any state):
  - next state IDLE, wait_cnt=0, mem_req=0, done pulses masked.
  - A store already accepted (done pulsed) is not undone.
- Simultaneous flush and mem_ready: flush wins; no done pulse.

## Timing
- Reset values: state=IDLE, wait_cnt=0, rdata registers=0, err_slot=0, bus_err=0.
- While reset=0, mem_req, stall, done and bus_err are forced to 0.
- mem_* outputs, stall, sN_done and sN_rdata are combinational from state and inputs. There is no registered latency added to the memory path.
- A slot's access latency equals the memory latency; slot 1 starts the cycle after slot 0 completes.
- bus_err is asserted in the ERR cycle, one cycle after the failing condition is detected.
- Reset deasserted mid-access: the arbiter restarts in IDLE and re-serves whatever the EX/MEM register presents.

## Structure
- Shared package pipeline_pkg:
  - typedef arb_state_t {IDLE, WAIT0, WAIT1, ERR}
  - localparam EXC_VECTOR=32'd60
  - cause codes CAUSE_MISALIGN, CAUSE_DMEM_TIMEOUT (exported for the Cause register)
- Sub-module dmem_wait_timer: counter with clear/enable and an expired output, parameterized by TIMEOUT.

## Test plan
- s0 load addr 0x10, mem_ready tied 1 → s0_done in the same cycle, stall never 1, s0_rdata=mem_rdata (0xDEADBEEF).
- s0 store 0x20 and s1 load 0x24, zero-wait memory → memory sees 0x20/we=1 then 0x24/we=0 on consecutive cycles, stall=1 for exactly one cycle, s1_rdata correct.
- s0 load with memory ready after 3 cycles, s1 none → stall=1 for 3 cycles, 0 in the ready cycle; s0_rdata held afterwards.
- s1 load addr 0x22 (misaligned), s0 idle → mem_req stays 0, bus_err pulses one cycle later, err_slot=1.
- mem_ready never asserted, TIMEOUT=16 → bus_err after 16 wait cycles, err_slot=0, arbiter back in IDLE.
- Dual request; flush asserted while in WAIT1 with mem_ready=1 → no s1_done, state IDLE next cycle, stall=0.
- Reset pulse while in WAIT0 → outputs go to reset values asynchronously.
